alu_multicycle: RTL and testbench

//  Parametrised, registered ALU for the MIPS datapath. Executes the single-cycle R-type ops
//  (AND/OR/ADD/SUB/SLT) plus iterative MULTU/DIVU into internal HI/LO registers, and MFHI/MFLO.

---
 rtl/alu_multicycle_if.sv | 13 +
 rtl/alu_multicycle.sv | 90 +++++++++
 tb/tb_alu_multicycle.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: start/busy/done request and result bus of the multicycle ALU
interface alu_multicycle_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [5:0]       Signal;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dataOut;
  logic             zero;
  modport master (output start, dataA, dataB, Signal, input busy, done, dataOut, zero);
  modport slave (input start, dataA, dataB, Signal, output busy, done, dataOut, zero);
endinterface

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered MIPS ALU with iterative MULTU/DIVU into HI/LO under a start/busy/done handshake
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset,
  alu_multicycle_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [5:0] F_AND = 6'd36, F_OR = 6'd37, F_ADD = 6'd32, F_SUB = 6'd34, F_SLT = 6'd42;
  localparam logic [5:0] F_MULTU = 6'd25, F_DIVU = 6'd27, F_MFHI = 6'd16, F_MFLO = 6'd18;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] hi, lo, opnd, res1, dout;
  logic [2*WIDTH-1:0] work, mul_nxt, div_nxt, step;
  logic [WIDTH:0] sum, sh, diff;
  logic is_div, accept, long_op, last, zr;
  assign accept = bus.start && state == IDLE;
  assign long_op = bus.Signal == F_MULTU || bus.Signal == F_DIVU;
  assign last = state == RUN && cnt == CW'(WIDTH - 1);
  assign bus.dataOut = dout;
  assign bus.zero = zr;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = long_op ? RUN : DONE;
    else if (last || state == DONE) state_nxt = last ? DONE : IDLE;
  end
  always_comb begin
    bus.busy = state != IDLE;
    bus.done = state == DONE;
  end
  // work holds {acc, multiplier} for MULTU and {remainder, dividend/quotient} for DIVU
  always_comb begin
    sum = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
    mul_nxt = {sum, work[WIDTH-1:1]};
    sh = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    diff = sh - {1'b0, opnd};
    div_nxt = diff[WIDTH] ? {sh[WIDTH-1:0], work[WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
    step = is_div ? div_nxt : mul_nxt;
  end
  always_comb begin
    res1 = '0;
    case (bus.Signal)
      F_AND: res1 = bus.dataA & bus.dataB;
      F_OR: res1 = bus.dataA | bus.dataB;
      F_ADD: res1 = bus.dataA + bus.dataB;
      F_SUB: res1 = bus.dataA - bus.dataB;
      F_SLT: res1 = {{(WIDTH-1){1'b0}}, $signed(bus.dataA) < $signed(bus.dataB)};
      F_MFHI: res1 = hi;
      F_MFLO: res1 = lo;
      default: res1 = '0;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      opnd <= '0;
      work <= '0;
      is_div <= 1'b0;
      dout <= '0;
      zr <= 1'b0;
    end else begin
      if (accept) begin
        work <= {{WIDTH{1'b0}}, bus.Signal == F_MULTU ? bus.dataB : bus.dataA};
        opnd <= bus.Signal == F_MULTU ? bus.dataA : bus.dataB;
        is_div <= bus.Signal == F_DIVU;
        cnt <= '0;
        if (!long_op) begin
          dout <= res1;
          zr <= res1 == '0;
        end
      end
      if (state == RUN) begin
        work <= step;
        cnt <= cnt + 1'b1;
      end
      if (last) begin
        hi <= step[2*WIDTH-1:WIDTH];
        lo <= step[WIDTH-1:0];
        dout <= step[WIDTH-1:0];
        zr <= step[WIDTH-1:0] == '0;
      end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed and random checks of 32- and 8-bit ALU instances against an arithmetic model
module tb_alu_multicycle;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  alu_multicycle_if #(.WIDTH(32)) b32();
  alu_multicycle_if #(.WIDTH(8)) b8();
  alu_multicycle #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
  alu_multicycle #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(b8.slave));
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mhi[2];
  logic [31:0] mlo[2];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input bit w8, input logic s, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      b8.start = s; b8.Signal = f; b8.dataA = a[7:0]; b8.dataB = b[7:0];
    end else begin
      b32.start = s; b32.Signal = f; b32.dataA = a; b32.dataB = b;
    end
  endtask
  function automatic logic get_done(input bit w8);
    return w8 ? b8.done : b32.done;
  endfunction
  function automatic logic get_busy(input bit w8);
    return w8 ? b8.busy : b32.busy;
  endfunction
  function automatic logic get_zero(input bit w8);
    return w8 ? b8.zero : b32.zero;
  endfunction
  function automatic logic [31:0] get_out(input bit w8);
    return w8 ? {24'b0, b8.dataOut} : b32.dataOut;
  endfunction
  task automatic model(input bit w8, input logic [5:0] f, input logic [31:0] a_in, input logic [31:0] b_in,
                       output logic [31:0] r, output int lat);
    int w;
    logic [31:0] m, a, b;
    logic [63:0] p;
    longint sa, sb;
    w = w8 ? 8 : 32;
    m = w8 ? 32'hFF : 32'hFFFF_FFFF;
    a = a_in & m;
    b = b_in & m;
    sa = w8 ? longint'($signed(a[7:0])) : longint'($signed(a));
    sb = w8 ? longint'($signed(b[7:0])) : longint'($signed(b));
    r = 0;
    lat = 1;
    case (f)
      6'd36: r = a & b;
      6'd37: r = a | b;
      6'd32: r = (a + b) & m;
      6'd34: r = (a - b) & m;
      6'd42: r = (sa < sb) ? 32'd1 : 32'd0;
      6'd25: begin
        p = {32'b0, a} * {32'b0, b};
        mlo[w8] = p[31:0] & m;
        mhi[w8] = 32'(p >> w) & m;
        r = mlo[w8];
        lat = w + 1;
      end
      6'd27: begin
        mlo[w8] = (b == 0) ? m : a / b;
        mhi[w8] = (b == 0) ? a : a % b;
        r = mlo[w8];
        lat = w + 1;
      end
      6'd16: r = mhi[w8];
      6'd18: r = mlo[w8];
      default: r = 0;
    endcase
  endtask
  task automatic run(input bit w8, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                     input bit hold, input string tag);
    logic [31:0] er;
    int elat, lat;
    model(w8, f, a, b, er, elat);
    @(negedge clk);
    drive(w8, 1'b1, f, a, b);
    @(posedge clk);
    #1;
    drive(w8, hold, f, $urandom, $urandom);
    lat = 1;
    while (!get_done(w8) && lat < 50) begin
      @(posedge clk);
      #1;
      if (hold) drive(w8, 1'b1, f, $urandom, $urandom);
      lat++;
    end
    drive(w8, 1'b0, f, $urandom, $urandom);
    chk({tag, " latency"}, lat, elat);
    chk({tag, " result"}, get_out(w8), er);
    chk({tag, " zero"}, get_zero(w8), er == 0);
    chk({tag, " busy_at_done"}, get_busy(w8), 1'b1);
    @(posedge clk);
    #1;
    chk({tag, " after_done"}, {get_busy(w8), get_done(w8)}, 2'b00);
  endtask
  initial begin
    logic [5:0] ops[9] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd25, 6'd27, 6'd16, 6'd18};
    logic [5:0] f;
    logic [31:0] a, b;
    int seen;
    bit w8;
    reset = 1'b1;
    drive(0, 1'b0, 6'd0, 0, 0);
    drive(1, 1'b0, 6'd0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset32 flags", {b32.busy, b32.done, b32.zero}, 3'b000);
    chk("reset32 dataOut", b32.dataOut, 0);
    chk("reset8 flags", {b8.busy, b8.done, b8.zero}, 3'b000);
    chk("reset8 dataOut", b8.dataOut, 0);
    mhi = '{0, 0};
    mlo = '{0, 0};
    @(negedge clk);
    reset = 1'b0;
    run(0, 6'd18, 0, 0, 0, "mflo_after_reset");
    run(0, 6'd32, 32'h7FFF_FFFF, 32'h1, 0, "add_wrap");
    run(0, 6'd34, 5, 5, 0, "sub_zero");
    run(0, 6'd42, 32'hFFFF_FFFF, 32'h1, 0, "slt_neg");
    run(0, 6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
    run(0, 6'd16, 0, 0, 0, "mfhi_multu_max");
    run(0, 6'd27, 100, 7, 0, "divu_100_7");
    run(0, 6'd16, 0, 0, 0, "mfhi_divu_100_7");
    run(0, 6'd27, 9, 0, 0, "divu_by_zero");
    run(0, 6'd16, 0, 0, 0, "mfhi_div0");
    run(0, 6'd18, 0, 0, 0, "mflo_div0");
    run(0, 6'd3, 32'h1234, 32'h5678, 0, "unknown_funct");
    run(0, 6'd25, $urandom, $urandom, 1, "multu_start_held");
    run(0, 6'd16, 0, 0, 0, "mfhi_start_held");
    @(negedge clk);
    drive(0, 1'b1, 6'd25, $urandom, $urandom);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 6'd25, 0, 0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midop_reset flags", {b32.busy, b32.done}, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    mhi = '{0, 0};
    mlo = '{0, 0};
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (b32.done) seen++;
    end
    chk("midop_reset no_done", seen, 0);
    run(0, 6'd16, 0, 0, 0, "mfhi_after_abort");
    run(0, 6'd18, 0, 0, 0, "mflo_after_abort");
    run(1, 6'd25, 32'hFF, 32'hFF, 0, "w8_multu");
    run(1, 6'd16, 0, 0, 0, "w8_mfhi_multu");
    run(1, 6'd27, 32'hFF, 32'h10, 0, "w8_divu");
    run(1, 6'd16, 0, 0, 0, "w8_mfhi_divu");
    for (int i = 0; i < 80; i++) begin
      w8 = 1'($urandom_range(0, 1));
      f = ($urandom_range(0, 9) == 9) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 8)];
      a = $urandom;
      b = (f == 6'd27 && $urandom_range(0, 2) == 0) ? $urandom_range(0, 20) : $urandom;
      run(w8, f, a, b, 1'($urandom_range(0, 1)), w8 ? "rand8" : "rand32");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
